// File: rtl/exec_stage_m.sv
// RV32 execute stage: single-cycle integer ALU plus an iterative RV32M engine
// (one multiplier/quotient bit per cycle) that stalls ID/EX while occupied.
module exec_stage_m #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            i_hold,
    input  logic            i_flush,
    input  logic            i_in_valid,
    output logic            o_in_ready,
    input  logic [4:0]      i_op,
    input  logic [XLEN-1:0] i_src1,
    input  logic [XLEN-1:0] i_src2,
    input  logic [XLEN-1:0] i_pc,
    input  logic [XLEN-1:0] i_imm,
    input  logic            i_use_pc,
    input  logic            i_use_imm,
    input  logic [4:0]      i_rd_in,
    input  logic            i_regwrite_in,
    output logic            o_out_valid,
    output logic [XLEN-1:0] o_result,
    output logic [4:0]      o_rd_out,
    output logic            o_regwrite_out,
    output logic            o_busy
);

    localparam int CNT_W = $clog2(XLEN) + 1;
    localparam int SH_W  = $clog2(XLEN);

    localparam logic [4:0] OP_ADD    = 5'd0;
    localparam logic [4:0] OP_SUB    = 5'd1;
    localparam logic [4:0] OP_AND    = 5'd2;
    localparam logic [4:0] OP_OR     = 5'd3;
    localparam logic [4:0] OP_XOR    = 5'd4;
    localparam logic [4:0] OP_SLL    = 5'd5;
    localparam logic [4:0] OP_SRL    = 5'd6;
    localparam logic [4:0] OP_SRA    = 5'd7;
    localparam logic [4:0] OP_SLT    = 5'd8;
    localparam logic [4:0] OP_SLTU   = 5'd9;
    localparam logic [4:0] OP_MUL    = 5'd16;
    localparam logic [4:0] OP_MULH   = 5'd17;
    localparam logic [4:0] OP_MULHSU = 5'd18;
    localparam logic [4:0] OP_DIV    = 5'd20;
    localparam logic [4:0] OP_REM    = 5'd22;

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV} state_t;

    function automatic logic [XLEN-1:0] f_alu(input logic [4:0] op,
                                              input logic [XLEN-1:0] a,
                                              input logic [XLEN-1:0] b);
        logic [SH_W-1:0] sh;
        sh = b[SH_W-1:0];
        case (op)
            OP_ADD:  return a + b;
            OP_SUB:  return a - b;
            OP_AND:  return a & b;
            OP_OR:   return a | b;
            OP_XOR:  return a ^ b;
            OP_SLL:  return a << sh;
            OP_SRL:  return a >> sh;
            OP_SRA:  return $signed(a) >>> sh;
            OP_SLT:  return {{(XLEN-1){1'b0}}, ($signed(a) < $signed(b))};
            OP_SLTU: return {{(XLEN-1){1'b0}}, (a < b)};
            default: return '0;
        endcase
    endfunction

    function automatic logic [XLEN-1:0] f_cneg(input logic neg, input logic [XLEN-1:0] v);
        return neg ? -v : v;
    endfunction

    function automatic logic [2*XLEN-1:0] f_cneg2(input logic neg, input logic [2*XLEN-1:0] v);
        return neg ? -v : v;
    endfunction

    state_t              r_state, w_state_nx;
    logic [CNT_W-1:0]    r_cnt, w_cnt_nx;
    logic                r_out_valid, w_ov_nx;
    logic [XLEN-1:0]     r_result;
    logic [4:0]          r_rd_out;
    logic                r_rw_out;

    logic [4:0]          r_op;
    logic [4:0]          r_rd;
    logic                r_rw;
    logic                r_neg;
    logic                r_neg_rem;
    logic [XLEN-1:0]     r_x;
    logic [2*XLEN-1:0]   r_y;
    logic [2*XLEN-1:0]   r_z;

    logic [XLEN-1:0]     w_a, w_b, w_mag_a, w_mag_b, w_base_res, w_m_res;
    logic                w_accept, w_is_m, w_is_div, w_sa, w_sb, w_div0, w_ovf;
    logic                w_ld_base, w_ld_fin, w_start, w_step;
    logic [2*XLEN-1:0]   w_mul_acc_nx, w_mul_p;
    logic [XLEN:0]       w_rem_sh, w_rem_nx;
    logic                w_rem_ge;
    logic [XLEN-1:0]     w_quo_nx, w_quo, w_rem;

    assign w_a        = i_use_pc  ? i_pc  : i_src1;
    assign w_b        = i_use_imm ? i_imm : i_src2;
    assign o_in_ready = (r_state == S_IDLE) && !i_hold;
    assign w_accept   = i_in_valid && o_in_ready && !i_flush;

    // Operand signs and divide special cases are decided at acceptance.
    assign w_is_m   = (i_op[4:3] == 2'b10);
    assign w_is_div = w_is_m && i_op[2];
    assign w_sa     = w_a[XLEN-1] && (i_op == OP_MUL || i_op == OP_MULH || i_op == OP_MULHSU
                                      || i_op == OP_DIV || i_op == OP_REM);
    assign w_sb     = w_b[XLEN-1] && (i_op == OP_MUL || i_op == OP_MULH
                                      || i_op == OP_DIV || i_op == OP_REM);
    assign w_mag_a  = f_cneg(w_sa, w_a);
    assign w_mag_b  = f_cneg(w_sb, w_b);
    assign w_div0   = w_is_div && (w_b == '0);
    assign w_ovf    = w_is_div && !i_op[0] && (w_a == {1'b1, {(XLEN-1){1'b0}}}) && (w_b == '1);

    always_comb begin
        w_base_res = f_alu(i_op, w_a, w_b);
        if (w_div0)
            w_base_res = i_op[1] ? w_a : '1;
        else if (w_ovf)
            w_base_res = i_op[1] ? '0 : w_a;
    end

    assign w_mul_acc_nx = r_z + (r_x[0] ? r_y : '0);
    assign w_rem_sh     = {r_z[XLEN-1:0], r_x[XLEN-1]};
    assign w_rem_ge     = (w_rem_sh >= {1'b0, r_y[XLEN-1:0]});
    assign w_rem_nx     = w_rem_ge ? (w_rem_sh - {1'b0, r_y[XLEN-1:0]}) : w_rem_sh;
    assign w_quo_nx     = {r_x[XLEN-2:0], w_rem_ge};

    // Sign fix applies to the final step's value, written on the last edge.
    assign w_mul_p = f_cneg2(r_neg, w_mul_acc_nx);
    assign w_quo   = f_cneg(r_neg, w_quo_nx);
    assign w_rem   = f_cneg(r_neg_rem, w_rem_nx[XLEN-1:0]);

    always_comb begin
        w_m_res = w_quo;
        if (r_state == S_MUL)
            w_m_res = (r_op == OP_MUL) ? w_mul_p[XLEN-1:0] : w_mul_p[2*XLEN-1:XLEN];
        else if (r_op[1])
            w_m_res = w_rem;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            r_state <= S_IDLE;
        else
            r_state <= w_state_nx;
    end

    always_comb begin
        w_state_nx = r_state;
        w_cnt_nx   = r_cnt;
        w_ov_nx    = r_out_valid;
        w_ld_base  = 1'b0;
        w_ld_fin   = 1'b0;
        w_start    = 1'b0;
        w_step     = 1'b0;
        if (i_flush) begin
            w_state_nx = S_IDLE;
            w_cnt_nx   = '0;
            w_ov_nx    = 1'b0;
        end else if (!i_hold) begin
            case (r_state)
                S_IDLE: begin
                    w_ov_nx = 1'b0;
                    if (w_accept) begin
                        if (w_is_m && !w_div0 && !w_ovf) begin
                            w_start    = 1'b1;
                            w_state_nx = w_is_div ? S_DIV : S_MUL;
                            w_cnt_nx   = CNT_W'(XLEN);
                        end else begin
                            w_ld_base = 1'b1;
                            w_ov_nx   = 1'b1;
                        end
                    end
                end
                default: begin
                    w_step   = 1'b1;
                    w_cnt_nx = r_cnt - CNT_W'(1);
                    w_ov_nx  = 1'b0;
                    if (r_cnt == CNT_W'(1)) begin
                        w_ld_fin   = 1'b1;
                        w_ov_nx    = 1'b1;
                        w_state_nx = S_IDLE;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt       <= '0;
            r_out_valid <= 1'b0;
            r_result    <= '0;
            r_rd_out    <= '0;
            r_rw_out    <= 1'b0;
        end else begin
            r_cnt       <= w_cnt_nx;
            r_out_valid <= w_ov_nx;
            if (w_ld_base) begin
                r_result <= w_base_res;
                r_rd_out <= i_rd_in;
                r_rw_out <= i_regwrite_in;
            end else if (w_ld_fin) begin
                r_result <= w_m_res;
                r_rd_out <= r_rd;
                r_rw_out <= r_rw;
            end else if (!w_ov_nx) begin
                r_rw_out <= 1'b0;
            end
        end
    end

    // M engine datapath: r_x is multiplier/quotient, r_y multiplicand/divisor,
    // r_z the running product/partial remainder.
    always_ff @(posedge clk) begin
        if (w_start) begin
            r_op      <= i_op;
            r_rd      <= i_rd_in;
            r_rw      <= i_regwrite_in;
            r_neg     <= w_sa ^ w_sb;
            r_neg_rem <= w_sa;
            r_x       <= w_is_div ? w_mag_a : w_mag_b;
            r_y       <= {{XLEN{1'b0}}, (w_is_div ? w_mag_b : w_mag_a)};
            r_z       <= '0;
        end else if (w_step) begin
            if (r_state == S_MUL) begin
                r_z <= w_mul_acc_nx;
                r_y <= {r_y[2*XLEN-2:0], 1'b0};
                r_x <= {1'b0, r_x[XLEN-1:1]};
            end else begin
                r_z <= {{(XLEN-1){1'b0}}, w_rem_nx};
                r_x <= w_quo_nx;
            end
        end
    end

    assign o_out_valid    = r_out_valid;
    assign o_result       = r_result;
    assign o_rd_out       = r_rd_out;
    assign o_regwrite_out = r_rw_out;
    assign o_busy         = (r_state != S_IDLE);

endmodule

// File: tb/tb_exec_stage_m.sv
// Directed bench for exec_stage_m: ALU stream, M ops, divide special cases,
// hold, flush and asynchronous reset during an iterative op.
module tb_exec_stage_m;
    localparam int XLEN = 32;

    logic            clk = 1'b0;
    logic            rst;
    logic            i_hold, i_flush, i_in_valid;
    logic            o_in_ready;
    logic [4:0]      i_op;
    logic [XLEN-1:0] i_src1, i_src2, i_pc, i_imm;
    logic            i_use_pc, i_use_imm;
    logic [4:0]      i_rd_in;
    logic            i_regwrite_in;
    logic            o_out_valid;
    logic [XLEN-1:0] o_result;
    logic [4:0]      o_rd_out;
    logic            o_regwrite_out;
    logic            o_busy;

    int cmp_cnt = 0;
    int err_cnt = 0;

    always #5 clk = ~clk;

    exec_stage_m #(.XLEN(XLEN)) dut (
        .clk(clk), .rst(rst), .i_hold(i_hold), .i_flush(i_flush),
        .i_in_valid(i_in_valid), .o_in_ready(o_in_ready), .i_op(i_op),
        .i_src1(i_src1), .i_src2(i_src2), .i_pc(i_pc), .i_imm(i_imm),
        .i_use_pc(i_use_pc), .i_use_imm(i_use_imm), .i_rd_in(i_rd_in),
        .i_regwrite_in(i_regwrite_in), .o_out_valid(o_out_valid),
        .o_result(o_result), .o_rd_out(o_rd_out),
        .o_regwrite_out(o_regwrite_out), .o_busy(o_busy)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
        i_in_valid = 1'b1; i_op = op; i_src1 = a; i_src2 = b;
        i_use_pc = 1'b0; i_use_imm = 1'b0; i_rd_in = 5'd9; i_regwrite_in = 1'b1;
    endtask

    // Issues one op, then counts edges after acceptance until out_valid (bounded).
    task automatic run_m(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                         output int k, output logic [31:0] res, output logic ok);
        issue(op, a, b);
        tick();
        i_in_valid = 1'b0;
        k = 0;
        ok = 1'b1;
        while (!o_out_valid && k < 100) begin
            if (!o_busy || o_in_ready || o_regwrite_out) ok = 1'b0;
            tick();
            k++;
        end
        res = o_result;
    endtask

    task automatic test_reset();
        rst = 1'b0; i_hold = 0; i_flush = 0; i_in_valid = 0; i_op = 0;
        i_src1 = 0; i_src2 = 0; i_pc = 0; i_imm = 0; i_use_pc = 0; i_use_imm = 0;
        i_rd_in = 0; i_regwrite_in = 0;
        tick(); tick();
        cmp_cnt++; if (o_out_valid !== 1'b0) begin err_cnt++; $display("FAIL reset_ov: got %b want 0", o_out_valid); end
        cmp_cnt++; if (o_result !== 32'h0) begin err_cnt++; $display("FAIL reset_result: got %h want 0", o_result); end
        cmp_cnt++; if (o_rd_out !== 5'd0 || o_regwrite_out !== 1'b0) begin err_cnt++; $display("FAIL reset_rd_rw: got %0d/%b want 0/0", o_rd_out, o_regwrite_out); end
        cmp_cnt++; if (o_busy !== 1'b0) begin err_cnt++; $display("FAIL reset_busy: got %b want 0", o_busy); end
        rst = 1'b1;
        tick();
        cmp_cnt++; if (o_in_ready !== 1'b1 || o_out_valid !== 1'b0) begin err_cnt++; $display("FAIL reset_release: got rdy=%b ov=%b want 1/0", o_in_ready, o_out_valid); end
    endtask

    task automatic test_alu_stream();
        issue(5'd0, 32'd5, 32'hFFFF_FFF9);
        tick();
        cmp_cnt++; if (o_result !== 32'hFFFF_FFFE || o_out_valid !== 1'b1) begin err_cnt++; $display("FAIL alu_add: got %h ov=%b want fffffffe ov=1", o_result, o_out_valid); end
        issue(5'd7, 32'h8000_0000, 32'd4);
        tick();
        cmp_cnt++; if (o_result !== 32'hF800_0000 || o_out_valid !== 1'b1) begin err_cnt++; $display("FAIL alu_sra: got %h ov=%b want f8000000 ov=1", o_result, o_out_valid); end
        issue(5'd9, 32'd1, 32'hFFFF_FFFF);
        tick();
        cmp_cnt++; if (o_result !== 32'd1 || o_out_valid !== 1'b1) begin err_cnt++; $display("FAIL alu_sltu: got %h ov=%b want 1 ov=1", o_result, o_out_valid); end
        cmp_cnt++; if (o_rd_out !== 5'd9 || o_regwrite_out !== 1'b1) begin err_cnt++; $display("FAIL alu_rd_rw: got %0d/%b want 9/1", o_rd_out, o_regwrite_out); end
        issue(5'd8, 32'hFFFF_FFFF, 32'd1);
        tick();
        cmp_cnt++; if (o_result !== 32'd1) begin err_cnt++; $display("FAIL alu_slt: got %h want 1", o_result); end
        i_in_valid = 1'b0;
        tick();
        cmp_cnt++; if (o_out_valid !== 1'b0 || o_regwrite_out !== 1'b0 || o_result !== 32'd1) begin err_cnt++; $display("FAIL alu_idle: got ov=%b rw=%b res=%h want 0/0/1", o_out_valid, o_regwrite_out, o_result); end
    endtask

    task automatic test_operands();
        issue(5'd0, 32'hDEAD_BEEF, 32'h1234_5678);
        i_use_pc = 1'b1; i_use_imm = 1'b1; i_pc = 32'h0000_1000; i_imm = 32'h10;
        tick();
        cmp_cnt++; if (o_result !== 32'h0000_1010) begin err_cnt++; $display("FAIL op_pc_imm: got %h want 00001010", o_result); end
        issue(5'd5, 32'd1, 32'd0);
        i_use_imm = 1'b1; i_imm = 32'h21;
        tick();
        cmp_cnt++; if (o_result !== 32'd2) begin err_cnt++; $display("FAIL op_sll_shamt: got %h want 2", o_result); end
        issue(5'd1, 32'd3, 32'd5);
        tick();
        cmp_cnt++; if (o_result !== 32'hFFFF_FFFE) begin err_cnt++; $display("FAIL op_sub: got %h want fffffffe", o_result); end
        issue(5'd12, 32'd3, 32'd5);
        tick();
        cmp_cnt++; if (o_result !== 32'd0 || o_out_valid !== 1'b1) begin err_cnt++; $display("FAIL op_unknown: got %h ov=%b want 0 ov=1", o_result, o_out_valid); end
        i_in_valid = 1'b0;
        tick();
    endtask

    task automatic test_mul();
        int k; logic [31:0] res; logic ok;
        run_m(5'd17, 32'hFFFF_FFFD, 32'h4000_0000, k, res, ok);
        cmp_cnt++; if (res !== 32'hFFFF_FFFF || k !== 32) begin err_cnt++; $display("FAIL mulh: got %h after %0d want ffffffff after 32", res, k); end
        cmp_cnt++; if (ok !== 1'b1) begin err_cnt++; $display("FAIL mulh_busy: got ok=%b want 1", ok); end
        cmp_cnt++; if (o_busy !== 1'b0 || o_in_ready !== 1'b1 || o_regwrite_out !== 1'b1 || o_rd_out !== 5'd9) begin err_cnt++; $display("FAIL mulh_done: got busy=%b rdy=%b rw=%b rd=%0d want 0/1/1/9", o_busy, o_in_ready, o_regwrite_out, o_rd_out); end
        run_m(5'd19, 32'hFFFF_FFFF, 32'hFFFF_FFFF, k, res, ok);
        cmp_cnt++; if (res !== 32'hFFFF_FFFE || k !== 32 || !ok) begin err_cnt++; $display("FAIL mulhu: got %h after %0d ok=%b want fffffffe after 32", res, k, ok); end
        run_m(5'd16, 32'd7, 32'hFFFF_FFFA, k, res, ok);
        cmp_cnt++; if (res !== 32'hFFFF_FFD6 || k !== 32) begin err_cnt++; $display("FAIL mul: got %h after %0d want ffffffd6 after 32", res, k); end
        run_m(5'd18, 32'hFFFF_FFFF, 32'hFFFF_FFFF, k, res, ok);
        cmp_cnt++; if (res !== 32'hFFFF_FFFF || k !== 32) begin err_cnt++; $display("FAIL mulhsu: got %h after %0d want ffffffff after 32", res, k); end
        tick();
    endtask

    task automatic test_div();
        int k; logic [31:0] res; logic ok;
        run_m(5'd20, 32'hFFFF_FFF9, 32'd2, k, res, ok);
        cmp_cnt++; if (res !== 32'hFFFF_FFFD || k !== 32 || !ok) begin err_cnt++; $display("FAIL div: got %h after %0d ok=%b want fffffffd after 32", res, k, ok); end
        run_m(5'd22, 32'hFFFF_FFF9, 32'd2, k, res, ok);
        cmp_cnt++; if (res !== 32'hFFFF_FFFF || k !== 32) begin err_cnt++; $display("FAIL rem: got %h after %0d want ffffffff after 32", res, k); end
        run_m(5'd23, 32'd1000, 32'd7, k, res, ok);
        cmp_cnt++; if (res !== 32'd6 || k !== 32) begin err_cnt++; $display("FAIL remu: got %h after %0d want 6 after 32", res, k); end
        run_m(5'd21, 32'd100, 32'd0, k, res, ok);
        cmp_cnt++; if (res !== 32'hFFFF_FFFF || k !== 0 || o_busy !== 1'b0) begin err_cnt++; $display("FAIL divu_by0: got %h after %0d busy=%b want ffffffff after 0 busy=0", res, k, o_busy); end
        run_m(5'd23, 32'd100, 32'd0, k, res, ok);
        cmp_cnt++; if (res !== 32'd100 || k !== 0) begin err_cnt++; $display("FAIL remu_by0: got %h after %0d want 64 after 0", res, k); end
        run_m(5'd20, 32'h8000_0000, 32'hFFFF_FFFF, k, res, ok);
        cmp_cnt++; if (res !== 32'h8000_0000 || k !== 0 || o_busy !== 1'b0) begin err_cnt++; $display("FAIL div_ovf: got %h after %0d busy=%b want 80000000 after 0 busy=0", res, k, o_busy); end
        run_m(5'd22, 32'h8000_0000, 32'hFFFF_FFFF, k, res, ok);
        cmp_cnt++; if (res !== 32'h0 || k !== 0) begin err_cnt++; $display("FAIL rem_ovf: got %h after %0d want 0 after 0", res, k); end
        tick();
    endtask

    task automatic test_hold();
        int k;
        issue(5'd0, 32'd1, 32'd2);
        tick();
        issue(5'd0, 32'd10, 32'd10);
        i_hold = 1'b1;
        #1;
        cmp_cnt++; if (o_in_ready !== 1'b0) begin err_cnt++; $display("FAIL hold_ready: got %b want 0", o_in_ready); end
        tick(); tick();
        cmp_cnt++; if (o_out_valid !== 1'b1 || o_result !== 32'd3) begin err_cnt++; $display("FAIL hold_freeze: got ov=%b res=%h want 1/3", o_out_valid, o_result); end
        i_hold = 1'b0; i_in_valid = 1'b0;
        tick();
        issue(5'd21, 32'd1000, 32'd7);
        tick();
        i_in_valid = 1'b0;
        repeat (5) tick();
        i_hold = 1'b1;
        repeat (3) tick();
        cmp_cnt++; if (o_busy !== 1'b1 || o_out_valid !== 1'b0 || o_in_ready !== 1'b0) begin err_cnt++; $display("FAIL hold_divu: got busy=%b ov=%b rdy=%b want 1/0/0", o_busy, o_out_valid, o_in_ready); end
        i_hold = 1'b0;
        k = 8;
        while (!o_out_valid && k < 100) begin tick(); k++; end
        cmp_cnt++; if (o_result !== 32'd142 || k !== 35) begin err_cnt++; $display("FAIL hold_divu_res: got %h after %0d want 8e after 35", o_result, k); end
        tick();
    endtask

    task automatic test_flush();
        int seen;
        issue(5'd16, 32'd3, 32'd5);
        tick();
        i_in_valid = 1'b0;
        repeat (19) tick();
        issue(5'd0, 32'd4, 32'd4);
        i_flush = 1'b1;
        tick();
        cmp_cnt++; if (o_out_valid !== 1'b0 || o_busy !== 1'b0 || o_in_ready !== 1'b1) begin err_cnt++; $display("FAIL flush_mul: got ov=%b busy=%b rdy=%b want 0/0/1", o_out_valid, o_busy, o_in_ready); end
        i_flush = 1'b0;
        tick();
        cmp_cnt++; if (o_out_valid !== 1'b1 || o_result !== 32'd8) begin err_cnt++; $display("FAIL flush_next_add: got ov=%b res=%h want 1/8", o_out_valid, o_result); end
        issue(5'd0, 32'd1, 32'd1);
        i_flush = 1'b1;
        tick();
        cmp_cnt++; if (o_out_valid !== 1'b0 || o_regwrite_out !== 1'b0 || o_result !== 32'd8) begin err_cnt++; $display("FAIL flush_idle: got ov=%b rw=%b res=%h want 0/0/8", o_out_valid, o_regwrite_out, o_result); end
        i_flush = 1'b0; i_in_valid = 1'b0;
        seen = 0;
        repeat (15) begin tick(); if (o_out_valid) seen++; end
        cmp_cnt++; if (seen !== 0) begin err_cnt++; $display("FAIL flush_no_late: got %0d valid cycles want 0", seen); end
    endtask

    task automatic test_reset_mid_div();
        int k; logic [31:0] res; logic ok;
        issue(5'd20, 32'd100, 32'd3);
        tick();
        i_in_valid = 1'b0;
        repeat (10) tick();
        #2 rst = 1'b0;
        #1;
        cmp_cnt++; if (o_busy !== 1'b0 || o_out_valid !== 1'b0 || o_result !== 32'h0 || o_rd_out !== 5'd0) begin err_cnt++; $display("FAIL rst_mid_div: got busy=%b ov=%b res=%h rd=%0d want 0/0/0/0", o_busy, o_out_valid, o_result, o_rd_out); end
        rst = 1'b1;
        issue(5'd0, 32'd20, 32'd22);
        tick();
        cmp_cnt++; if (o_result !== 32'd42 || o_out_valid !== 1'b1) begin err_cnt++; $display("FAIL rst_then_add: got %h ov=%b want 2a ov=1", o_result, o_out_valid); end
        run_m(5'd20, 32'd100, 32'hFFFF_FFFD, k, res, ok);
        cmp_cnt++; if (res !== 32'hFFFF_FFDF || k !== 32) begin err_cnt++; $display("FAIL rst_then_div: got %h after %0d want ffffffdf after 32", res, k); end
    endtask

    initial begin
        test_reset();
        test_alu_stream();
        test_operands();
        test_mul();
        test_div();
        test_hold();
        test_flush();
        test_reset_mid_div();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
        $finish;
    end

endmodule
